// File: rtl/emu_ckpt_scan_ctrl.sv
// Checkpoint dump/restore sequencer over the EMU FF and RAM scan chains.
// Optional: `define EMU_CKPT_CHECKSUM_EN builds the XOR checksum of transferred words.
module emu_ckpt_scan_ctrl #(
  parameter int FF_WORDS  = 3,
  parameter int RAM_WORDS = 4,
  parameter int RAM_PRIME = 2
) (
  input  logic        host_clk,
  input  logic        host_rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  output logic        done,
  output logic        run_mode,
  output logic        scan_mode,
  output logic        ff_se,
  output logic [63:0] ff_di,
  input  logic [63:0] ff_do,
  output logic        ram_sr,
  output logic        ram_se,
  output logic        ram_sd,
  output logic [63:0] ram_di,
  input  logic [63:0] ram_do,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        m_last,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic [63:0] ckpt_sum
);

  localparam int MAXW = (FF_WORDS > RAM_WORDS) ? FF_WORDS : RAM_WORDS;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int PW   = (RAM_PRIME < 1) ? 1 : $clog2(RAM_PRIME + 1);
  localparam logic [CW-1:0] FF_LAST    = CW'(FF_WORDS - 1);
  localparam logic [CW-1:0] RAM_LAST   = CW'(RAM_WORDS - 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(RAM_PRIME - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PAUSE, S_SCAN_ON, S_FF, S_PRIME, S_RAM, S_TAIL, S_UNSCAN, S_RESUME
  } state_t;

  state_t        r_state, w_next;
  logic          r_op;
  logic [CW-1:0] r_wcnt;
  logic [PW-1:0] r_pcnt;
  logic          w_wlast, w_plast, w_xfer;

  assign w_wlast = (r_state == S_FF) ? (r_wcnt == FF_LAST) : (r_wcnt == RAM_LAST);
  assign w_plast = (r_pcnt == PRIME_LAST);
  assign w_xfer  = ((r_state == S_FF) || (r_state == S_RAM)) && (ff_se || ram_se);

  always_ff @(posedge host_clk or negedge host_rstn) begin
    if (!host_rstn) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_wcnt  <= '0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (cmd_valid && cmd_ready) r_op <= cmd_op;
      // One word counter serves both chains; it returns to 0 on each chain's last word.
      if (w_xfer) r_wcnt <= w_wlast ? '0 : r_wcnt + CW'(1);
      if (r_state == S_PRIME) r_pcnt <= w_plast ? '0 : r_pcnt + PW'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    run_mode  = 1'b0;
    scan_mode = 1'b0;
    ff_se     = 1'b0;
    ff_di     = '0;
    ram_sr    = 1'b0;
    ram_se    = 1'b0;
    ram_sd    = 1'b0;
    ram_di    = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    s_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        run_mode  = 1'b1;
        if (cmd_valid) w_next = S_PAUSE;
      end
      S_PAUSE:   w_next = S_SCAN_ON;
      S_SCAN_ON: begin
        scan_mode = 1'b1;
        ram_sr    = 1'b1;
        w_next    = S_FF;
      end
      S_FF: begin
        scan_mode = 1'b1;
        if (!r_op) begin
          // Dump rotates the FF chain so target state survives the read.
          m_valid = 1'b1;
          m_data  = ff_do;
          ff_di   = ff_do;
          ff_se   = m_ready;
        end else begin
          s_ready = 1'b1;
          ff_di   = s_data;
          ff_se   = s_valid;
        end
        if (ff_se && w_wlast)
          w_next = (r_op || RAM_PRIME == 0) ? S_RAM : S_PRIME;
      end
      S_PRIME: begin
        scan_mode = 1'b1;
        ram_se    = 1'b1;
        if (w_plast) w_next = S_RAM;
      end
      S_RAM: begin
        scan_mode = 1'b1;
        if (!r_op) begin
          m_valid = 1'b1;
          m_data  = ram_do;
          m_last  = w_wlast;
          ram_se  = m_ready;
        end else begin
          ram_sd  = 1'b1;
          s_ready = 1'b1;
          ram_di  = s_data;
          ram_se  = s_valid;
        end
        if (ram_se && w_wlast) w_next = r_op ? S_TAIL : S_UNSCAN;
      end
      S_TAIL: begin
        scan_mode = 1'b1;
        ram_se    = 1'b1;
        ram_sd    = 1'b1;
        w_next    = S_UNSCAN;
      end
      S_UNSCAN: w_next = S_RESUME;
      S_RESUME: begin
        run_mode = 1'b1;
        done     = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef EMU_CKPT_CHECKSUM_EN
  logic [63:0] r_sum;
  always_ff @(posedge host_clk or negedge host_rstn) begin
    if (!host_rstn)                  r_sum <= '0;
    else if (cmd_valid && cmd_ready) r_sum <= '0;
    else if (w_xfer)                 r_sum <= r_sum ^ (r_op ? s_data : m_data);
  end
  assign ckpt_sum = r_sum;
`else
  assign ckpt_sum = '0;
`endif

endmodule

// File: tb/tb_emu_ckpt_scan_ctrl.sv
// Bench for emu_ckpt_scan_ctrl: behavioural scan-chain target plus per-scenario checks.
module tb_emu_ckpt_scan_ctrl;
  localparam int FFW = 3;
  localparam int RW  = 4;
  localparam int RP  = 2;

  logic        host_clk = 1'b0, host_rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_op = 1'b0, cmd_ready, done, run_mode, scan_mode;
  logic        ff_se, ram_sr, ram_se, ram_sd;
  logic [63:0] ff_di, ff_do, ram_di, ram_do;
  logic        m_valid, m_ready = 1'b0, m_last, s_valid = 1'b0, s_ready;
  logic [63:0] m_data, s_data = '0, ckpt_sum;

  int checks = 0, errors = 0;

  emu_ckpt_scan_ctrl #(.FF_WORDS(FFW), .RAM_WORDS(RW), .RAM_PRIME(RP)) dut (
    .host_clk(host_clk), .host_rstn(host_rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .done(done), .run_mode(run_mode), .scan_mode(scan_mode), .ff_se(ff_se),
    .ff_di(ff_di), .ff_do(ff_do), .ram_sr(ram_sr), .ram_se(ram_se), .ram_sd(ram_sd),
    .ram_di(ram_di), .ram_do(ram_do), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .ckpt_sum(ckpt_sum)
  );

  always #5 host_clk = ~host_clk;

  // Target model: FF chain shifts toward word 0; RAM chain reads after RP discarded enables.
  logic [63:0] ff_chain [FFW];
  logic [63:0] mem      [RW];
  logic [63:0] ff_init  [FFW];
  logic [63:0] mem_init [RW];
  logic        load_req = 1'b0;
  int          rptr = 0, wptr = 0;

  assign ff_do = ff_chain[0];
  always_comb begin
    ram_do = 64'hDEAD_BEEF_DEAD_BEEF;
    if (rptr >= RP && rptr - RP < RW) ram_do = mem[rptr - RP];
  end

  always @(posedge host_clk) begin
    if (load_req) begin
      for (int i = 0; i < FFW; i++) ff_chain[i] <= ff_init[i];
      for (int i = 0; i < RW; i++)  mem[i]      <= mem_init[i];
    end else begin
      if (ff_se) begin
        for (int i = 0; i < FFW - 1; i++) ff_chain[i] <= ff_chain[i + 1];
        ff_chain[FFW - 1] <= ff_di;
      end
      if (ram_sr) begin
        rptr <= 0;
        wptr <= 0;
      end else if (ram_se) begin
        if (ram_sd) begin
          if (wptr < RW) mem[wptr] <= ram_di;
          wptr <= wptr + 1;
        end else rptr <= rptr + 1;
      end
    end
  end

  typedef struct packed {
    logic ffse, ramse, ramsd, mv, mr, sv, sr, crdy, run, scan;
  } cyc_t;

  cyc_t        log_q[$];
  logic [63:0] beat_q[$], ffdi_q[$], ramdi_q[$], rq[$], exp_q[$];
  logic        last_q[$];
  int          done_c, rq_idx;
  bit          tmo;

  task automatic load_chain();
    for (int i = 0; i < FFW; i++) ff_init[i]  = {$urandom, $urandom};
    for (int i = 0; i < RW; i++)  mem_init[i] = {$urandom, $urandom};
    exp_q.delete();
    for (int i = 0; i < FFW; i++) exp_q.push_back(ff_init[i]);
    for (int i = 0; i < RW; i++)  exp_q.push_back(mem_init[i]);
    @(negedge host_clk);
    load_req = 1'b1;
    @(negedge host_clk);
    load_req = 1'b0;
  endtask

  // Issues one command and logs every cycle until done; cycle 1 is the first cycle after the handshake.
  task automatic run_op(input bit op, input int pct, input bit hold, input int abort_beats);
    cyc_t e;
    log_q.delete(); beat_q.delete(); last_q.delete(); ffdi_q.delete(); ramdi_q.delete();
    done_c = -1; tmo = 1'b0; rq_idx = 0;
    @(negedge host_clk);
    cmd_valid = 1'b1; cmd_op = op; m_ready = 1'b0; s_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge host_clk);
      cmd_valid = hold;
      m_ready   = ($urandom_range(99) < pct);
      s_valid   = ($urandom_range(99) < pct);
      s_data    = (rq_idx < rq.size()) ? rq[rq_idx] : 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      e = '{ffse: ff_se, ramse: ram_se, ramsd: ram_sd, mv: m_valid, mr: m_ready, sv: s_valid,
             sr: s_ready, crdy: cmd_ready, run: run_mode, scan: scan_mode};
      log_q.push_back(e);
      if (m_valid && m_ready) begin beat_q.push_back(m_data); last_q.push_back(m_last); end
      if (ff_se) ffdi_q.push_back(ff_di);
      if (ram_se && ram_sd && s_ready) ramdi_q.push_back(ram_di);
      if (s_valid && s_ready) rq_idx++;
      if (abort_beats > 0 && beat_q.size() >= abort_beats) begin
        host_rstn = 1'b0;
        #1;
        return;
      end
      if (done) begin
        done_c = c; cmd_valid = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
        return;
      end
    end
    tmo = 1'b1; cmd_valid = 1'b0;
  endtask

  function automatic logic [63:0] exp_sum();
    logic [63:0] x = '0;
`ifdef EMU_CKPT_CHECKSUM_EN
    for (int i = 0; i < exp_q.size(); i++) x ^= exp_q[i];
`endif
    return x;
  endfunction

  task automatic test_reset();
    host_rstn = 1'b0;
    repeat (2) @(negedge host_clk);
    #1;
    checks++; if (run_mode !== 1'b1) begin errors++; $display("FAIL reset_run_mode: got %b want 1", run_mode); end
    checks++; if ({scan_mode, ff_se, ram_sr, ram_se, ram_sd, m_valid, m_last, s_ready, done} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl_outs: got %b want 0", {scan_mode, ff_se, ram_sr, ram_se, ram_sd, m_valid, m_last, s_ready, done});
    end
    checks++; if ({m_data, ff_di, ram_di, ckpt_sum} !== 256'b0) begin
      errors++; $display("FAIL reset_data_outs: got %h %h %h %h want 0", m_data, ff_di, ram_di, ckpt_sum);
    end
    @(negedge host_clk);
    host_rstn = 1'b1;
  endtask

  task automatic test_dump_ready();
    int bub;
    load_chain();
    run_op(1'b0, 100, 1'b0, 0);
    checks++; if (tmo) begin errors++; $display("FAIL dump_ready_timeout: got no done want done"); end
    checks++; if (done_c !== 4 + FFW + RP + RW) begin errors++; $display("FAIL dump_ready_latency: got %0d want %0d", done_c, 4 + FFW + RP + RW); end
    checks++; if (beat_q.size() !== FFW + RW) begin errors++; $display("FAIL dump_ready_beats: got %0d want %0d", beat_q.size(), FFW + RW); end
    for (int i = 0; i < beat_q.size() && i < FFW + RW; i++) begin
      checks++; if (beat_q[i] !== exp_q[i] || last_q[i] !== (i == FFW + RW - 1)) begin
        errors++; $display("FAIL dump_ready_beat%0d: got %h last %b want %h last %b", i, beat_q[i], last_q[i], exp_q[i], i == FFW + RW - 1);
      end
    end
    bub = 0;
    for (int k = 0; k < FFW; k++) if (log_q.size() > 2 + k && !log_q[2 + k].ffse) bub++;
    for (int k = 0; k < RP; k++) if (log_q.size() > 2 + FFW + k && !(log_q[2 + FFW + k].ramse && !log_q[2 + FFW + k].mv)) bub++;
    for (int k = 0; k < RW; k++) if (log_q.size() > 2 + FFW + RP + k && !log_q[2 + FFW + RP + k].ramse) bub++;
    checks++; if (bub != 0) begin errors++; $display("FAIL dump_ready_no_bubble: got %0d gaps want 0", bub); end
    bub = 0;
    foreach (log_q[i]) if (log_q[i].crdy) bub++;
    checks++; if (bub != 0) begin errors++; $display("FAIL dump_ready_cmd_ready_busy: got %0d high cycles want 0", bub); end
    @(negedge host_clk); @(negedge host_clk);
    checks++; if (ckpt_sum !== exp_sum()) begin errors++; $display("FAIL dump_ready_sum: got %h want %h", ckpt_sum, exp_sum()); end
    checks++; if (ff_chain[0] !== ff_init[0] || ff_chain[FFW - 1] !== ff_init[FFW - 1]) begin
      errors++; $display("FAIL dump_ready_rotate: got %h/%h want %h/%h", ff_chain[0], ff_chain[FFW - 1], ff_init[0], ff_init[FFW - 1]);
    end
    checks++; if ({cmd_ready, run_mode, scan_mode} !== 3'b110) begin errors++; $display("FAIL dump_ready_idle: got %b want 110", {cmd_ready, run_mode, scan_mode}); end
  endtask

  task automatic test_dump_random();
    int bad_se, drops, stalls, ovl, nbad;
    run_op(1'b0, 50, 1'b0, 0);
    bad_se = 0; drops = 0; stalls = 0; ovl = 0; nbad = 0;
    foreach (log_q[i]) begin
      if (log_q[i].mv && ((log_q[i].ffse | log_q[i].ramse) !== log_q[i].mr)) bad_se++;
      if (log_q[i].mv && !log_q[i].mr) begin
        stalls++;
        if (i + 1 < log_q.size() && !log_q[i + 1].mv) drops++;
      end
      if (log_q[i].ffse && log_q[i].ramse) ovl++;
    end
    for (int i = 0; i < FFW + RW; i++) if (i >= beat_q.size() || beat_q[i] !== exp_q[i]) nbad++;
    checks++; if (tmo) begin errors++; $display("FAIL dump_rand_timeout: got no done want done"); end
    checks++; if (nbad != 0 || beat_q.size() != FFW + RW) begin errors++; $display("FAIL dump_rand_seq: got %0d wrong of %0d want 0 of %0d", nbad, beat_q.size(), FFW + RW); end
    checks++; if (bad_se != 0) begin errors++; $display("FAIL dump_rand_se_eq_ready: got %0d bad cycles want 0", bad_se); end
    checks++; if (drops != 0) begin errors++; $display("FAIL dump_rand_valid_drop: got %0d want 0", drops); end
    checks++; if (ovl != 0) begin errors++; $display("FAIL dump_rand_se_overlap: got %0d want 0", ovl); end
    checks++; if (done_c !== 4 + FFW + RP + RW + stalls) begin errors++; $display("FAIL dump_rand_latency: got %0d want %0d", done_c, 4 + FFW + RP + RW + stalls); end
  endtask

  task automatic test_restore();
    int nbad, tails, stalls, bad_se;
    logic [63:0] x;
    rq.delete();
    for (int i = 1; i <= FFW + RW; i++) rq.push_back(64'(i));
    run_op(1'b1, 50, 1'b0, 0);
    checks++; if (tmo) begin errors++; $display("FAIL restore_timeout: got no done want done"); end
    nbad = 0;
    for (int i = 0; i < FFW; i++) if (i >= ffdi_q.size() || ffdi_q[i] !== 64'(i + 1)) nbad++;
    checks++; if (nbad != 0 || ffdi_q.size() != FFW) begin errors++; $display("FAIL restore_ff_di: got %0d wrong of %0d want 0 of %0d", nbad, ffdi_q.size(), FFW); end
    nbad = 0;
    for (int i = 0; i < RW; i++) if (i >= ramdi_q.size() || ramdi_q[i] !== 64'(FFW + i + 1)) nbad++;
    checks++; if (nbad != 0 || ramdi_q.size() != RW) begin errors++; $display("FAIL restore_ram_di: got %0d wrong of %0d want 0 of %0d", nbad, ramdi_q.size(), RW); end
    tails = 0; stalls = 0; bad_se = 0;
    foreach (log_q[i]) begin
      if (log_q[i].ramse && log_q[i].ramsd && !log_q[i].sr) tails++;
      if (log_q[i].sr && !log_q[i].sv) stalls++;
      if (log_q[i].sr && ((log_q[i].ffse | log_q[i].ramse) !== log_q[i].sv)) bad_se++;
      if (log_q[i].ffse && log_q[i].ramse) bad_se++;
    end
    checks++; if (tails != 1 || done_c < 3 || !log_q[done_c - 3].ramse || log_q[done_c - 3].sr) begin
      errors++; $display("FAIL restore_tail: got %0d tail cycles want 1 two cycles before done", tails);
    end
    checks++; if (bad_se != 0) begin errors++; $display("FAIL restore_se_eq_valid: got %0d bad cycles want 0", bad_se); end
    checks++; if (rq_idx != FFW + RW) begin errors++; $display("FAIL restore_accept_count: got %0d want %0d", rq_idx, FFW + RW); end
    checks++; if (done_c !== 3 + FFW + RW + 2 + stalls) begin errors++; $display("FAIL restore_latency: got %0d want %0d", done_c, 3 + FFW + RW + 2 + stalls); end
    checks++; if (done_c >= 2 && (log_q[done_c - 2].run || log_q[done_c - 2].scan)) begin errors++; $display("FAIL restore_unscan: got run/scan high want both 0"); end
    @(negedge host_clk); @(negedge host_clk);
    x = '0;
`ifdef EMU_CKPT_CHECKSUM_EN
    for (int i = 0; i < rq.size(); i++) x ^= rq[i];
`endif
    checks++; if (ckpt_sum !== x) begin errors++; $display("FAIL restore_sum: got %h want %h", ckpt_sum, x); end
    checks++; if (run_mode !== 1'b1) begin errors++; $display("FAIL restore_run_mode: got %b want 1", run_mode); end
    exp_q.delete();
    for (int i = 0; i < rq.size(); i++) exp_q.push_back(rq[i]);
    rq.delete();
  endtask

  task automatic test_redump();
    int nbad;
    run_op(1'b0, 100, 1'b0, 0);
    nbad = 0;
    for (int i = 0; i < FFW + RW; i++) if (i >= beat_q.size() || beat_q[i] !== 64'(i + 1)) nbad++;
    checks++; if (tmo || nbad != 0 || beat_q.size() != FFW + RW) begin
      errors++; $display("FAIL redump_seq: got %0d wrong of %0d want 0 of %0d", nbad, beat_q.size(), FFW + RW);
    end
    @(negedge host_clk);
    checks++; if (ckpt_sum !== exp_sum()) begin errors++; $display("FAIL redump_sum: got %h want %h", ckpt_sum, exp_sum()); end
  endtask

  task automatic test_cmd_hold();
    int busy_rdy, extra;
    load_chain();
    run_op(1'b0, 100, 1'b1, 0);
    busy_rdy = 0;
    foreach (log_q[i]) if (log_q[i].crdy) busy_rdy++;
    checks++; if (tmo || beat_q.size() != FFW + RW) begin errors++; $display("FAIL hold_one_op_beats: got %0d want %0d", beat_q.size(), FFW + RW); end
    checks++; if (busy_rdy != 0) begin errors++; $display("FAIL hold_cmd_ready_busy: got %0d want 0", busy_rdy); end
    extra = 0;
    repeat (4) begin
      @(negedge host_clk); #1;
      if (scan_mode || !cmd_ready || !run_mode) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL hold_no_second_op: got %0d busy cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int nbad;
    run_op(1'b0, 100, 1'b0, FFW + 2);
    checks++; if ({run_mode, scan_mode, ram_se, m_valid} !== 4'b1000) begin
      errors++; $display("FAIL midreset_outs: got %b want 1000", {run_mode, scan_mode, ram_se, m_valid});
    end
    @(negedge host_clk); #1;
    checks++; if ({run_mode, scan_mode, ram_se, m_valid, ckpt_sum} !== {4'b1000, 64'b0}) begin
      errors++; $display("FAIL midreset_next_cycle: got %b sum %h want 1000 sum 0", {run_mode, scan_mode, ram_se, m_valid}, ckpt_sum);
    end
    host_rstn = 1'b1;
    run_op(1'b0, 100, 1'b0, 0);
    nbad = 0;
    for (int i = 0; i < FFW + RW; i++) if (i >= beat_q.size() || beat_q[i] !== exp_q[i]) nbad++;
    checks++; if (tmo || nbad != 0 || done_c !== 4 + FFW + RP + RW) begin
      errors++; $display("FAIL midreset_redump: got %0d wrong beats latency %0d want 0 and %0d", nbad, done_c, 4 + FFW + RP + RW);
    end
  endtask

  initial begin
    test_reset();
    test_dump_ready();
    test_dump_random();
    test_restore();
    test_redump();
    test_cmd_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
